tb_check_unit: RTL and testbench

Clocked, parametrised self-checking unit for test benches. It compares up to CHANNELS actual/expected sample pairs per cycle and counts passes and failures. It captures the first failure, runs a cycle watchdog, and reports a single run verdict. It sits between the stimulus driver and the DUT outputs in every bench, replacing ad-hoc per-assert flag tracking and free-running timeouts with one synthesizable, observable block.

---
 rtl/tb_check_pkg.sv | 26 ++
 rtl/tb_lane_cmp.sv | 21 ++
 rtl/tb_check_unit.sv | 154 +++++++++++++++
 tb/tb_tb_check_unit.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tb_check_pkg.sv
// Shared types and helpers for the tb_check_unit verdict block.
package tb_check_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DONE    = 2'd2,
        TIMEOUT = 2'd3
    } tb_check_state_t;

    // Lane field is at most $clog2(16)+1 bits; users truncate to their own width.
    localparam int unsigned MAX_LANE_W = 5;
    localparam logic [MAX_LANE_W-1:0] NO_FAIL = '1;

    // Saturating add for counters up to 32 bits wide.
    function automatic logic [31:0] sat_add(input logic [31:0] cnt,
                                            input logic [31:0] inc,
                                            input int unsigned cnt_w);
        logic [32:0] sum;
        logic [32:0] max;
        sum = {1'b0, cnt} + {1'b0, inc};
        max = (33'(1) << cnt_w) - 33'(1);
        return (sum > max) ? max[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/tb_lane_cmp.sv
// Single-lane masked compare; a lane with valid_i low neither passes nor fails.
module tb_lane_cmp
    import tb_check_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             valid_i,
    input  logic [WIDTH-1:0] actual_i,
    input  logic [WIDTH-1:0] expected_i,
    input  logic [WIDTH-1:0] mask_i,
    output logic             pass_c,
    output logic             fail_c
);

    logic mismatch_c;

    assign mismatch_c = |((actual_i ^ expected_i) & mask_i);
    assign pass_c     = valid_i & ~mismatch_c;
    assign fail_c     = valid_i & mismatch_c;

endmodule

// File: rtl/tb_check_unit.sv
// Multi-lane compare/verdict unit with pass/fail counters, first-fail capture and watchdog.
// Define TB_CHECK_STOP_ON_FAIL_EN to end the run on the edge after the first failing cycle.
module tb_check_unit
    import tb_check_pkg::*;
#(
    parameter int unsigned CHANNELS       = 4,
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                                CLK,
    input  logic                                RST_N,
    input  logic                                start,
    input  logic                                finish,
    input  logic [CHANNELS-1:0]                 valid,
    input  logic [CHANNELS*WIDTH-1:0]           mask,
    input  logic [CHANNELS*WIDTH-1:0]           actual,
    input  logic [CHANNELS*WIDTH-1:0]           expected,
    output logic                                busy,
    output logic                                done,
    output logic                                all_ok,
    output logic                                timed_out,
    output logic [CNT_W-1:0]                    pass_count,
    output logic [CNT_W-1:0]                    fail_count,
    output logic [$clog2(CHANNELS)+1-1:0]       first_fail_lane,
    output logic [$clog2(TIMEOUT_CYCLES+1)-1:0] first_fail_cycle
);

    localparam int unsigned LW = $clog2(CHANNELS) + 1;
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned PW = $clog2(CHANNELS + 1);
    localparam logic [CW-1:0] LAST_CYCLE = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [LW-1:0] NO_LANE    = LW'(NO_FAIL);

    tb_check_state_t state_q, state_d;
    logic [CNT_W-1:0] pass_q, pass_d, fail_q, fail_d;
    logic [LW-1:0]    lane_q, lane_d;
    logic [CW-1:0]    fcyc_q, fcyc_d, cycle_q, cycle_d;
    logic             busy_q, done_q, all_ok_q, to_q;

    logic                run_c, arm_c, stop_c;
    logic [CHANNELS-1:0] pass_vec_c, fail_vec_c;
    logic [PW-1:0]       n_pass_c, n_fail_c;
    logic [LW-1:0]       fail_lane_c;

    assign run_c = (state_q == RUN);
    assign arm_c = start && (state_q != RUN);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        tb_lane_cmp #(.WIDTH(WIDTH)) u_lane (
            .valid_i    (valid[i] & run_c),
            .actual_i   (actual[i*WIDTH +: WIDTH]),
            .expected_i (expected[i*WIDTH +: WIDTH]),
            .mask_i     (mask[i*WIDTH +: WIDTH]),
            .pass_c     (pass_vec_c[i]),
            .fail_c     (fail_vec_c[i])
        );
    end

    // Popcounts and lowest-index failing lane.
    always_comb begin
        n_pass_c    = '0;
        n_fail_c    = '0;
        fail_lane_c = NO_LANE;
        for (int i = 0; i < CHANNELS; i++) begin
            n_pass_c = n_pass_c + PW'(pass_vec_c[i]);
            n_fail_c = n_fail_c + PW'(fail_vec_c[i]);
        end
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (fail_vec_c[i]) fail_lane_c = LW'(i);
        end
    end

`ifdef TB_CHECK_STOP_ON_FAIL_EN
    assign stop_c = |fail_vec_c;
`else
    assign stop_c = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state; finish takes priority over the watchdog.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, TIMEOUT: if (start) state_d = RUN;
            RUN: begin
                if (finish || stop_c)          state_d = DONE;
                else if (cycle_q == LAST_CYCLE) state_d = TIMEOUT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pass_d  = pass_q;
        fail_d  = fail_q;
        lane_d  = lane_q;
        fcyc_d  = fcyc_q;
        cycle_d = cycle_q;
        if (arm_c) begin
            pass_d  = '0;
            fail_d  = '0;
            lane_d  = NO_LANE;
            fcyc_d  = '0;
            cycle_d = '0;
        end else if (run_c) begin
            pass_d = CNT_W'(sat_add(32'(pass_q), 32'(n_pass_c), CNT_W));
            fail_d = CNT_W'(sat_add(32'(fail_q), 32'(n_fail_c), CNT_W));
            if ((|fail_vec_c) && (lane_q == NO_LANE)) begin
                lane_d = fail_lane_c;
                fcyc_d = cycle_q;
            end
            if (cycle_q != LAST_CYCLE) cycle_d = cycle_q + CW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pass_q   <= '0;
            fail_q   <= '0;
            lane_q   <= NO_LANE;
            fcyc_q   <= '0;
            cycle_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            all_ok_q <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            pass_q   <= pass_d;
            fail_q   <= fail_d;
            lane_q   <= lane_d;
            fcyc_q   <= fcyc_d;
            cycle_q  <= cycle_d;
            busy_q   <= (state_d == RUN);
            done_q   <= (state_d == DONE) || (state_d == TIMEOUT);
            all_ok_q <= (state_d == DONE) && (fail_d == '0);
            to_q     <= (state_d == TIMEOUT);
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign all_ok           = all_ok_q;
    assign timed_out        = to_q;
    assign pass_count       = pass_q;
    assign fail_count       = fail_q;
    assign first_fail_lane  = lane_q;
    assign first_fail_cycle = fcyc_q;

endmodule

// File: tb/tb_tb_check_unit.sv
// Scoreboard bench for tb_check_unit: per-cycle expectations from a behavioural model.
module tb_tb_check_unit;

    localparam int unsigned CH   = 4;
    localparam int unsigned W    = 8;
    localparam int unsigned T    = 32;
    localparam int unsigned CNTW = 6;
    localparam int unsigned LW   = $clog2(CH) + 1;
    localparam int unsigned CYW  = $clog2(T + 1);
    localparam int          MAXC = (1 << CNTW) - 1;
    localparam int          NONE = (1 << LW) - 1;
`ifdef TB_CHECK_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic              CLK = 1'b0;
    logic              RST_N = 1'b0;
    logic              start = 1'b0;
    logic              finish = 1'b0;
    logic [CH-1:0]     valid = '0;
    logic [CH*W-1:0]   mask = '0;
    logic [CH*W-1:0]   actual = '0;
    logic [CH*W-1:0]   expected = '0;
    logic              busy, done, all_ok, timed_out;
    logic [CNTW-1:0]   pass_count, fail_count;
    logic [LW-1:0]     first_fail_lane;
    logic [CYW-1:0]    first_fail_cycle;

    tb_check_unit #(
        .CHANNELS(CH), .WIDTH(W), .TIMEOUT_CYCLES(T), .CNT_W(CNTW)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .finish(finish),
        .valid(valid), .mask(mask), .actual(actual), .expected(expected),
        .busy(busy), .done(done), .all_ok(all_ok), .timed_out(timed_out),
        .pass_count(pass_count), .fail_count(fail_count),
        .first_fail_lane(first_fail_lane), .first_fail_cycle(first_fail_cycle)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit busy; bit done; bit all_ok; bit to;
        int pass; int fail; int ffl; int ffc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    // Behavioural model of the run.
    bit m_run, m_done, m_to;
    int m_cycle, m_pass, m_fail, m_ffl, m_ffc;

    function automatic void cmp(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_run = 0; m_done = 0; m_to = 0;
        m_cycle = 0; m_pass = 0; m_fail = 0; m_ffl = -1; m_ffc = 0;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.busy   = m_run;
        e.done   = m_done;
        e.to     = m_to;
        e.all_ok = m_done && !m_to && (m_fail == 0);
        e.pass   = m_pass;
        e.fail   = m_fail;
        e.ffl    = (m_ffl < 0) ? NONE : m_ffl;
        e.ffc    = m_ffc;
        return e;
    endfunction

    // One clock edge of the reference behaviour using the currently driven inputs.
    function automatic void model_step();
        int np, nf;
        logic [W-1:0] a, x, m;
        if (!m_run) begin
            if (start) begin
                m_run = 1; m_done = 0; m_to = 0;
                m_cycle = 0; m_pass = 0; m_fail = 0; m_ffl = -1; m_ffc = 0;
            end
            return;
        end
        np = 0; nf = 0;
        for (int i = 0; i < CH; i++) begin
            if (valid[i]) begin
                a = actual[i*W +: W];
                x = expected[i*W +: W];
                m = mask[i*W +: W];
                if (((a ^ x) & m) == '0) np++;
                else begin
                    nf++;
                    if (m_ffl < 0) begin m_ffl = i; m_ffc = m_cycle; end
                end
            end
        end
        m_pass = (m_pass + np > MAXC) ? MAXC : m_pass + np;
        m_fail = (m_fail + nf > MAXC) ? MAXC : m_fail + nf;
        if (finish || (STOP && nf > 0)) begin
            m_run = 0; m_done = 1;
        end else if (m_cycle == T - 1) begin
            m_run = 0; m_done = 1; m_to = 1;
        end else begin
            m_cycle++;
        end
    endfunction

    function automatic void check_all(string tag, exp_t e);
        cmp({tag, ".busy"},   int'(busy),             int'(e.busy));
        cmp({tag, ".done"},   int'(done),             int'(e.done));
        cmp({tag, ".all_ok"}, int'(all_ok),           int'(e.all_ok));
        cmp({tag, ".to"},     int'(timed_out),        int'(e.to));
        cmp({tag, ".pass"},   int'(pass_count),       e.pass);
        cmp({tag, ".fail"},   int'(fail_count),       e.fail);
        cmp({tag, ".ffl"},    int'(first_fail_lane),  e.ffl);
        cmp({tag, ".ffc"},    int'(first_fail_cycle), e.ffc);
    endfunction

    // Monitor: one expectation per clock edge, checked on the falling edge.
    always @(negedge CLK) begin
        if (RST_N && sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check_all("cyc", mon_e);
        end
    end

    task automatic step(input bit s, input bit f, input logic [CH-1:0] v,
                        input logic [CH*W-1:0] m, input logic [CH*W-1:0] a,
                        input logic [CH*W-1:0] e);
        start = s; finish = f; valid = v; mask = m; actual = a; expected = e;
        model_step();
        sb_q.push_back(model_out());
        @(posedge CLK);
        @(negedge CLK);
        #1;
    endtask

    task automatic idle(input bit s, input bit f);
        step(s, f, '0, '0, '0, '0);
    endtask

    task automatic rand_samples(input int fail_pct, output logic [CH-1:0] v,
                                output logic [CH*W-1:0] m, output logic [CH*W-1:0] a,
                                output logic [CH*W-1:0] e);
        logic [W-1:0] ev, mv, d;
        for (int i = 0; i < CH; i++) begin
            v[i] = ($urandom_range(0, 3) != 0);
            ev = W'($urandom);
            case ($urandom_range(0, 3))
                0:       mv = '1;
                1:       mv = '0;
                default: mv = W'($urandom);
            endcase
            if (($urandom_range(0, 99) < fail_pct) && (mv != '0)) begin
                d = W'($urandom) & mv;
                if (d == '0) d = mv;
            end else begin
                d = W'($urandom) & ~mv;
            end
            e[i*W +: W] = ev;
            m[i*W +: W] = mv;
            a[i*W +: W] = ev ^ d;
        end
    endtask

    logic [CH-1:0]   rv;
    logic [CH*W-1:0] rm, ra, re;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench still running at %0t", $time);
        $fatal(1, "bench did not terminate");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge CLK);
        @(negedge CLK); #1;
        check_all("reset", model_out());
        RST_N = 1'b1;

        // finish in IDLE is ignored
        idle(0, 1);
        idle(0, 0);

        // Clean run
        idle(1, 0);
        repeat (10) step(0, 0, '1, {CH{8'hFF}}, {CH{8'hA5}}, {CH{8'hA5}});
        idle(0, 1);
        cmp("clean.pass", int'(pass_count), 40);
        cmp("clean.all_ok", int'(all_ok), 1);
        cmp("clean.ffl", int'(first_fail_lane), NONE);

        // Masked miss then lanes 1 and 3 fail; start during RUN ignored
        idle(1, 0);
        step(0, 0, 4'b0100, 32'h00F0_0000, 32'h000F_0000, 32'h0);
        step(1, 0, 4'b1111, 32'hFFFF_FFFF, 32'h0100_0100, 32'h0);
        idle(0, 1);
        cmp("masked.fail", int'(fail_count), 2);
        cmp("masked.ffl", int'(first_fail_lane), 1);
        cmp("masked.ffc", int'(first_fail_cycle), 1);

        // Watchdog expiry after exactly T RUN cycles
        idle(1, 0);
        for (int c = 0; c < T; c++) begin
            rand_samples(0, rv, rm, ra, re);
            step(0, 0, rv, rm, ra, re);
        end
        cmp("wd.to", int'(timed_out), 1);
        cmp("wd.all_ok", int'(all_ok), 0);
        idle(0, 1);

        // finish on the last allowed cycle wins over the watchdog
        idle(1, 0);
        repeat (T - 1) idle(0, 0);
        idle(0, 1);
        cmp("wd_fin.done", int'(done), 1);
        cmp("wd_fin.to", int'(timed_out), 0);

        // Counter saturation
        idle(1, 0);
        repeat (20) step(0, 0, '1, '1, {CH{8'h3C}}, {CH{8'h3C}});
        idle(0, 1);
        cmp("sat.pass", int'(pass_count), MAXC);

        // Failure on RUN cycle 4
        idle(1, 0);
        repeat (4) step(0, 0, '1, '1, {CH{8'h11}}, {CH{8'h11}});
        step(0, 0, 4'b0100, '1, 32'h0080_0000, 32'h0);
        cmp("stop.done", int'(done), int'(STOP));
        cmp("stop.fail", int'(fail_count), 1);
        repeat (3) step(0, 0, '1, '1, {CH{8'h22}}, {CH{8'h22}});
        idle(0, 1);

        // Randomized runs, including random start pulses mid-run
        for (int r = 0; r < 14; r++) begin
            int len;
            len = $urandom_range(1, T + 4);
            idle(1, 0);
            for (int k = 0; k < len; k++) begin
                rand_samples(20, rv, rm, ra, re);
                step(($urandom_range(0, 9) == 0), (k == len - 1), rv, rm, ra, re);
            end
            idle(0, 0);
        end

        // Asynchronous reset between edges after three failures
        idle(1, 0);
        step(0, 0, 4'b0011, '1, 32'h0000_0101, 32'h0);
        step(0, 0, 4'b1000, '1, 32'h4000_0000, 32'h0);
        RST_N = 1'b0;
        #1;
        model_reset();
        check_all("async_rst", model_out());
        #1;
        RST_N = 1'b1;
        idle(0, 1);
        idle(1, 0);
        repeat (3) step(0, 0, '1, '1, {CH{8'h5A}}, {CH{8'h5A}});
        idle(0, 1);
        cmp("post_rst.pass", int'(pass_count), 12);
        cmp("post_rst.all_ok", int'(all_ok), 1);

        idle(0, 0);
        cmp("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
